// File: rtl/riscv_csr_dbg_port.sv
// riscv_csr_dbg_port: debug-port CSR access that borrows the core's CSR bus through a halt handshake.
module riscv_csr_dbg_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          RO_CHECK       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dbg_req_i,
  input  logic [11:0] dbg_addr_i,
  input  logic [31:0] dbg_wdata_i,
  input  logic [1:0]  dbg_op_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  output logic        core_halt_req_o,
  input  logic        core_halted_i,
  output logic        csr_access_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  output logic [1:0]  csr_op_o,
  input  logic [31:0] csr_rdata_i,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, HALT_WAIT, ACCESS, RESP} state_e;
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]  op_q, op_d;
  logic        err_q, err_d;
  logic        run, gnt, ro_hit, timeout;
  assign run     = ~rst;
  assign gnt     = state_q == IDLE && dbg_req_i;
  assign ro_hit  = RO_CHECK && dbg_op_i != 2'd0 && dbg_addr_i[11:10] == 2'b11;
  assign timeout = !core_halted_i && (cnt_q + 8'd1 == 8'(TIMEOUT_CYCLES));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = gnt ? dbg_addr_i : addr_q;
    wdata_d = gnt ? dbg_wdata_i : wdata_q;
    op_d    = gnt ? dbg_op_i : op_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (gnt) begin
        state_d = ro_hit ? RESP : HALT_WAIT;
        err_d   = ro_hit;
        cnt_d   = 8'd0;
        rdata_d = ro_hit ? 32'd0 : rdata_q;
      end
      HALT_WAIT: begin
        // halt wins over a timeout reached in the same cycle
        state_d = core_halted_i ? ACCESS : (timeout ? RESP : HALT_WAIT);
        cnt_d   = core_halted_i ? cnt_q : cnt_q + 8'd1;
        err_d   = timeout;
        rdata_d = timeout ? 32'd0 : rdata_q;
      end
      ACCESS: begin
        state_d = RESP;
        err_d   = 1'b0;
        rdata_d = csr_rdata_i;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign dbg_gnt_o       = run && gnt;
  assign dbg_rvalid_o    = run && state_q == RESP;
  assign dbg_err_o       = dbg_rvalid_o && err_q;
  assign dbg_rdata_o     = run ? rdata_q : 32'd0;
  assign core_halt_req_o = run && (state_q == HALT_WAIT || state_q == ACCESS);
  assign csr_access_o    = run && state_q == ACCESS;
  assign csr_addr_o      = csr_access_o ? addr_q : 12'd0;
  assign csr_wdata_o     = csr_access_o ? wdata_q : 32'd0;
  assign csr_op_o        = csr_access_o ? op_q : 2'd0;
  assign busy_o          = run && state_q != IDLE;
endmodule

// File: tb/tb_riscv_csr_dbg_port.sv
// tb_riscv_csr_dbg_port: scoreboard bench for the CSR debug port (default and short-timeout instances).
module tb_riscv_csr_dbg_port;
  logic        clk, rst, req, halted, sel;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [1:0]  dop;
  logic        a_gnt, a_rvalid, a_err, a_halt, a_access, a_busy;
  logic        t_gnt, t_rvalid, t_err, t_halt, t_access, t_busy;
  logic [31:0] a_rdata, a_wd, a_csr_rd, t_rdata, t_wd, t_csr_rd;
  logic [11:0] a_addr, t_addr;
  logic [1:0]  a_op, t_op;
  logic        o_gnt, o_rvalid, o_err, o_halt, o_access, o_busy;
  logic [31:0] o_rdata, o_wd;
  logic [11:0] o_addr;
  logic [1:0]  o_op;
  int n_chk = 0, n_fail = 0;
  logic [32:0] sb[$];

  function automatic logic [31:0] rmodel(input logic [11:0] a);
    return a == 12'h341 ? 32'h0000_1234 : {20'hABCDE, a};
  endfunction

  assign a_csr_rd = rmodel(a_addr);
  assign t_csr_rd = rmodel(t_addr);

  riscv_csr_dbg_port u_dut (
    .clk(clk), .rst(rst), .dbg_req_i(req & ~sel), .dbg_addr_i(addr), .dbg_wdata_i(wdata),
    .dbg_op_i(dop), .dbg_gnt_o(a_gnt), .dbg_rvalid_o(a_rvalid), .dbg_rdata_o(a_rdata),
    .dbg_err_o(a_err), .core_halt_req_o(a_halt), .core_halted_i(halted), .csr_access_o(a_access),
    .csr_addr_o(a_addr), .csr_wdata_o(a_wd), .csr_op_o(a_op), .csr_rdata_i(a_csr_rd), .busy_o(a_busy)
  );

  riscv_csr_dbg_port #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk(clk), .rst(rst), .dbg_req_i(req & sel), .dbg_addr_i(addr), .dbg_wdata_i(wdata),
    .dbg_op_i(dop), .dbg_gnt_o(t_gnt), .dbg_rvalid_o(t_rvalid), .dbg_rdata_o(t_rdata),
    .dbg_err_o(t_err), .core_halt_req_o(t_halt), .core_halted_i(halted), .csr_access_o(t_access),
    .csr_addr_o(t_addr), .csr_wdata_o(t_wd), .csr_op_o(t_op), .csr_rdata_i(t_csr_rd), .busy_o(t_busy)
  );

  assign {o_gnt, o_rvalid, o_err, o_halt, o_access, o_busy} = sel ?
    {t_gnt, t_rvalid, t_err, t_halt, t_access, t_busy} : {a_gnt, a_rvalid, a_err, a_halt, a_access, a_busy};
  assign o_rdata = sel ? t_rdata : a_rdata;
  assign o_wd    = sel ? t_wd : a_wd;
  assign o_addr  = sel ? t_addr : a_addr;
  assign o_op    = sel ? t_op : a_op;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (o_rvalid) begin
      if (sb.size() == 0) chk("rvalid_unexpected", 32'(o_rvalid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_rdata", o_rdata, e[31:0]);
        chk("sb_err", 32'(o_err), 32'(e[32]));
      end
    end
  end

  task automatic zeros(input string tag);
    chk({tag, "_ctl"}, 32'({o_gnt, o_rvalid, o_err, o_halt, o_access, o_busy, o_op}), 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
    chk({tag, "_caddr"}, 32'(o_addr), 32'd0);
    chk({tag, "_cwdata"}, o_wd, 32'd0);
  endtask

  // hd: cycle (grant = 0) from which core_halted_i is 1
  task automatic txn(input logic s, input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                     input int hd, input logic e_err, input int e_lat, input int e_halt);
    int lat, hc, ac;
    lat = -1; hc = 0; ac = 0;
    @(posedge clk); #1;
    sel = s; req = 1'b1; addr = a; dop = op; wdata = wd; halted = (hd == 0);
    sb.push_back({e_err, e_err ? 32'd0 : rmodel(a)});
    @(negedge clk);
    chk("gnt", 32'(o_gnt), 32'd1);
    for (int c = 1; c <= 300 && lat < 0; c++) begin
      @(posedge clk); #1;
      req = 1'b0; halted = (c >= hd);
      @(negedge clk);
      hc += int'(o_halt);
      if (o_access) begin
        ac++;
        chk("csr_addr", 32'(o_addr), 32'(a));
        chk("csr_op", 32'(o_op), 32'(op));
        chk("csr_wdata", o_wd, wd);
      end
      if (o_rvalid) lat = c;
    end
    chk("latency", lat, e_lat);
    chk("halt_cycles", hc, e_halt);
    chk("access_pulses", ac, e_err ? 0 : 1);
  endtask

  initial begin
    int g1, g2, r1, ac;
    rst = 1'b1; sel = 1'b0; req = 1'b1; halted = 1'b1; addr = 12'h341; dop = 2'd1; wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    zeros("reset");
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0; halted = 1'b0;
    txn(1'b0, 12'h341, 2'd0, 32'd0, 0, 1'b0, 3, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rdata_hold", o_rdata, 32'h0000_1234);
    txn(1'b0, 12'h300, 2'd1, 32'h1, 5, 1'b0, 7, 6);
    txn(1'b1, 12'h305, 2'd2, 32'h55, 1000, 1'b1, 5, 4);
    txn(1'b1, 12'h305, 2'd3, 32'hF0, 4, 1'b0, 6, 5);
    txn(1'b0, 12'hF10, 2'd2, 32'h5, 0, 1'b1, 1, 0);
    txn(1'b0, 12'hF10, 2'd0, 32'h0, 0, 1'b0, 3, 2);
    txn(1'b0, 12'hC00, 2'd3, 32'h3, 0, 1'b1, 1, 0);
    txn(1'b0, 12'hBFF, 2'd2, 32'h8, 0, 1'b0, 3, 2);
    // back-to-back with request held high
    g1 = -1; g2 = -1; r1 = -1; ac = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      sel = 1'b0; halted = 1'b1; dop = 2'd0;
      req = (g2 < 0);
      addr = (g1 < 0) ? 12'h341 : 12'h7A0;
      @(negedge clk);
      if (o_gnt) begin
        if (g1 < 0) g1 = c; else g2 = c;
        sb.push_back({1'b0, rmodel(addr)});
      end
      ac += int'(o_access);
      if (o_rvalid && r1 < 0) r1 = c;
    end
    chk("b2b_gnt1", g1, 0);
    chk("b2b_resp1", r1, 3);
    chk("b2b_gnt2", g2, 4);
    chk("b2b_access", ac, 2);
    // reset while in HALT_WAIT
    @(posedge clk); #1;
    req = 1'b1; addr = 12'h340; dop = 2'd1; wdata = 32'h77; halted = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("hw_halt_req", 32'(o_halt), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    zeros("rst_hw");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hw_after", 32'({o_halt, o_busy, o_rvalid}), 32'd0);
    // reset while in ACCESS
    @(posedge clk); #1;
    req = 1'b1; addr = 12'h341; dop = 2'd0; halted = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("acc_halt_req", 32'(o_halt), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    zeros("rst_acc");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_acc_no_resp", 32'({o_rvalid, o_halt, o_busy}), 32'd0);
      @(posedge clk); #1;
    end
    txn(1'b0, 12'h342, 2'd0, 32'd0, 0, 1'b0, 3, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
